axis_dwidth_upsizer: RTL and testbench

AXI4-Stream width upsizer: packs NUM_REG consecutive narrow slave beats of WIDTH bits into one master beat of WIDTH*NUM_REG bits. The first accepted beat lands in the least-significant lane. It is the inverse of axis_dwidth_downsizer, so a downsizer→upsizer chain returns the original stream bit-exactly. Packet boundaries (tlast) are preserved, and short packet tails are flushed as partial words.

---
 rtl/axis_width_pkg.sv | 33 +++
 rtl/axis_dwidth_upsizer_out_reg.sv | 66 ++++++
 rtl/axis_dwidth_upsizer.sv | 162 ++++++++++++++++
 tb/tb_axis_dwidth_upsizer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_width_pkg.sv
// -----------------------------------------------------------------------------
// axis_width_pkg
// Shared definitions for the AXI4-Stream width converters
// (axis_dwidth_upsizer / axis_dwidth_downsizer).
//   - AXIS_DEF_WIDTH / AXIS_DEF_NUM_REG : default lane width and lane count
//   - lane_cnt_w()                      : lane-counter width for a lane count,
//                                         never narrower than 1 bit
//   - lane_cnt_t                        : lane-counter type for the defaults
//   - lane_lsb()                        : bit offset of a lane in a packed word
// No ports (package).
// -----------------------------------------------------------------------------
package axis_width_pkg;

    localparam int AXIS_DEF_WIDTH   = 32;
    localparam int AXIS_DEF_NUM_REG = 2;

    // Width of a counter that spans 0..num_reg-1; a single lane pair still
    // needs one bit, so clamp the minimum at 1.
    function automatic int lane_cnt_w(input int num_reg);
        return (num_reg > 2) ? $clog2(num_reg) : 1;
    endfunction

    localparam int AXIS_DEF_CNT_W = lane_cnt_w(AXIS_DEF_NUM_REG);

    typedef logic [AXIS_DEF_CNT_W-1:0] lane_cnt_t;

    // LSB position of lane 'lane' in a word built from 'width'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/axis_dwidth_upsizer_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single-entry AXI4-Stream holding register. A new payload is loaded whenever
// the register is empty or is being drained in the same cycle, so a word can
// be handed over back-to-back without a bubble. While the consumer stalls the
// payload is frozen.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (clears valid and data)
//   load_valid  : producer offers a payload
//   load_ready  : register can take a payload this cycle (comb. from m_ready)
//   load_data   : payload to capture
//   m_valid     : register holds a payload
//   m_ready     : consumer accepts the held payload
//   m_data      : held payload
// -----------------------------------------------------------------------------
module axis_out_reg
    import axis_width_pkg::*;
#(
    parameter int DATA_W = AXIS_DEF_WIDTH * AXIS_DEF_NUM_REG + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              load_fire;

    // Empty, or emptying this cycle: either way the slot is free at the edge.
    assign load_ready = !valid_q || m_ready;
    assign load_fire  = load_valid && load_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_fire) begin
            // Covers both a fresh load and a reload on a draining cycle.
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;

endmodule

// File: rtl/axis_dwidth_upsizer.sv
// -----------------------------------------------------------------------------
// axis_dwidth_upsizer
// Packs NUM_REG consecutive WIDTH-bit slave beats into one WIDTH*NUM_REG-bit
// master word, first beat in the least-significant lane. A tlast beat closes
// the word early; lanes above it are zero. Inverse of axis_dwidth_downsizer.
//
// Optional feature macro: AXIS_UPSIZER_TKEEP_EN
//   defined   -> m_axis_tkeep port present, one flag per populated lane
//   undefined -> no tkeep port; partial words are marked by tlast only
//
// Ports:
//   aclk, areset   : clock, asynchronous active-high reset
//   s_axis_tvalid  : slave beat valid
//   s_axis_tready  : slave beat accepted (comb. from m_axis_tready on the
//                    beat that completes a word)
//   s_axis_tdata   : slave lane data (WIDTH)
//   s_axis_tlast   : last beat of packet
//   m_axis_tvalid  : master word valid
//   m_axis_tready  : downstream ready
//   m_axis_tdata   : packed word, lane k at [k*WIDTH +: WIDTH]
//   m_axis_tkeep   : per-lane valid flags (AXIS_UPSIZER_TKEEP_EN only)
//   m_axis_tlast   : word holds the last beat of a packet
//
// NUM_REG must be at least 2.
// -----------------------------------------------------------------------------
module axis_dwidth_upsizer
    import axis_width_pkg::*;
#(
    parameter int WIDTH   = AXIS_DEF_WIDTH,
    parameter int NUM_REG = AXIS_DEF_NUM_REG
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [WIDTH-1:0]         s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [WIDTH*NUM_REG-1:0] m_axis_tdata,
`ifdef AXIS_UPSIZER_TKEEP_EN
    output logic [NUM_REG-1:0]       m_axis_tkeep,
`endif
    output logic                     m_axis_tlast
);

    localparam int CNT_W  = lane_cnt_w(NUM_REG);
    localparam int WORD_W = WIDTH * NUM_REG;
    localparam int ACC_W  = WIDTH * (NUM_REG - 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Stage 0: lane counter and accumulator (lanes 0..NUM_REG-2)
    cnt_t              lane_cnt_q;
    cnt_t              lane_cnt_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;

    logic              completing;
    logic              accept;
    logic              load_valid;
    logic              load_ready;
    logic [WORD_W-1:0] load_word;

    // The last lane never needs storage: the beat that fills it goes
    // straight into the output register together with the accumulator.
    assign completing = (lane_cnt_q == cnt_t'(NUM_REG - 1)) || s_axis_tlast;

    // Filling beats only touch the accumulator, so they never wait on the
    // output side; only the beat that produces a word can stall.
    assign s_axis_tready = completing ? load_ready : 1'b1;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign load_valid    = s_axis_tvalid && completing;

    // Word assembled from the accumulator plus the incoming beat. Lanes above
    // lane_cnt stay zero so short tails are zero-padded.
    always_comb begin
        load_word = '0;
        for (int k = 0; k < NUM_REG - 1; k++) begin
            if (k < int'(lane_cnt_q)) begin
                load_word[lane_lsb(k, WIDTH) +: WIDTH] = acc_q[lane_lsb(k, WIDTH) +: WIDTH];
            end
        end
        for (int k = 0; k < NUM_REG; k++) begin
            if (k == int'(lane_cnt_q)) begin
                load_word[lane_lsb(k, WIDTH) +: WIDTH] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        acc_d      = acc_q;
        if (accept) begin
            if (completing) begin
                lane_cnt_d = '0;
                acc_d      = '0;
            end else begin
                for (int k = 0; k < NUM_REG - 1; k++) begin
                    if (k == int'(lane_cnt_q)) begin
                        acc_d[lane_lsb(k, WIDTH) +: WIDTH] = s_axis_tdata;
                    end
                end
                lane_cnt_d = lane_cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lane_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            acc_q      <= acc_d;
        end
    end

    // Stage 1: output holding register; payload = {[keep,] last, data}
`ifdef AXIS_UPSIZER_TKEEP_EN
    localparam int PAYLOAD_W = WORD_W + 1 + NUM_REG;

    logic [NUM_REG-1:0] load_keep;

    always_comb begin
        load_keep = '0;
        for (int k = 0; k < NUM_REG; k++) begin
            if (k <= int'(lane_cnt_q)) begin
                load_keep[k] = 1'b1;
            end
        end
    end

    logic [PAYLOAD_W-1:0] load_payload;
    logic [PAYLOAD_W-1:0] m_payload;

    assign load_payload = {load_keep, s_axis_tlast, load_word};
    assign {m_axis_tkeep, m_axis_tlast, m_axis_tdata} = m_payload;
`else
    localparam int PAYLOAD_W = WORD_W + 1;

    logic [PAYLOAD_W-1:0] load_payload;
    logic [PAYLOAD_W-1:0] m_payload;

    assign load_payload = {s_axis_tlast, load_word};
    assign {m_axis_tlast, m_axis_tdata} = m_payload;
`endif

    axis_out_reg #(
        .DATA_W (PAYLOAD_W)
    ) u_out_reg (
        .clk        (aclk),
        .rst        (areset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_payload),
        .m_valid    (m_axis_tvalid),
        .m_ready    (m_axis_tready),
        .m_data     (m_payload)
    );

endmodule

// File: tb/tb_axis_dwidth_upsizer.sv
module tb_axis_dwidth_upsizer;

    localparam int WIDTH   = 32;
    localparam int NUM_REG = 2;
    localparam int WW      = WIDTH * NUM_REG;

    logic              aclk = 1'b0;
    logic              areset;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [WIDTH-1:0]  s_axis_tdata;
    logic              s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [WW-1:0]     m_axis_tdata;
    logic              m_axis_tlast;
`ifdef AXIS_UPSIZER_TKEEP_EN
    logic [NUM_REG-1:0] m_axis_tkeep;
`endif

    always #5 aclk = ~aclk;

    axis_dwidth_upsizer #(
        .WIDTH   (WIDTH),
        .NUM_REG (NUM_REG)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
`ifdef AXIS_UPSIZER_TKEEP_EN
        .m_axis_tkeep  (m_axis_tkeep),
`endif
        .m_axis_tlast  (m_axis_tlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: beats collected into a list; a word is emitted when
    // the list holds NUM_REG beats or a tlast beat arrives.
    typedef struct {
        logic [WW-1:0]      data;
        logic               last;
        logic [NUM_REG-1:0] keep;
    } word_t;

    word_t            exp_q[$];
    logic [WIDTH-1:0] part[$];
    logic             comp_prev = 1'b0;
    logic             hold_prev = 1'b0;
    logic [WW-1:0]    hold_data;
    logic             hold_last;
    int               words_out = 0;

    always @(negedge aclk) begin
        word_t w;
        logic  exp_rdy;
        if (areset) begin
            exp_q.delete();
            part.delete();
            comp_prev = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (comp_prev) chk("latency_valid", m_axis_tvalid, 1'b1);
            if (hold_prev) begin
                chk("hold_valid", m_axis_tvalid, 1'b1);
                chk("hold_data", m_axis_tdata, hold_data);
                chk("hold_last", m_axis_tlast, hold_last);
            end
            exp_rdy = ((part.size() == NUM_REG - 1) || s_axis_tlast) ?
                      (!m_axis_tvalid || m_axis_tready) : 1'b1;
            chk("s_tready", s_axis_tready, exp_rdy);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_axis_tvalid, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", m_axis_tdata, w.data);
                    chk("word_last", m_axis_tlast, w.last);
`ifdef AXIS_UPSIZER_TKEEP_EN
                    chk("word_keep", m_axis_tkeep, w.keep);
`endif
                    words_out++;
                end
            end
            comp_prev = 1'b0;
            if (s_axis_tvalid && s_axis_tready) begin
                part.push_back(s_axis_tdata);
                if (part.size() == NUM_REG || s_axis_tlast) begin
                    w.data = '0;
                    foreach (part[i]) w.data[i*WIDTH +: WIDTH] = part[i];
                    w.last = s_axis_tlast;
                    w.keep = NUM_REG'((1 << part.size()) - 1);
                    exp_q.push_back(w);
                    part.delete();
                    comp_prev = 1'b1;
                end
            end
            hold_prev = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            hold_last = m_axis_tlast;
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            ok = s_axis_tready;
            cyc();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) chk("send_timeout", ok, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] cur_d;
        logic             cur_l;
        logic             acc;
        int               idx;
        int               cyc_n;
        int               w0;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;

        // reset state
        #1;
        chk("rst_valid", m_axis_tvalid, 1'b0);
        chk("rst_data", m_axis_tdata, 64'h0);
        chk("rst_last", m_axis_tlast, 1'b0);
`ifdef AXIS_UPSIZER_TKEEP_EN
        chk("rst_keep", m_axis_tkeep, 2'b00);
`endif
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        chk("rdy_after_rst", s_axis_tready, 1'b1);
        cyc();

        // basic pack
        m_axis_tready = 1'b1;
        send(32'h0000_0064, 1'b0);
        chk("basic_novalid", m_axis_tvalid, 1'b0);
        send(32'h0000_0001, 1'b0);
        chk("basic_valid", m_axis_tvalid, 1'b1);
        chk("basic_data", m_axis_tdata, 64'h00000001_00000064);
        chk("basic_last", m_axis_tlast, 1'b0);
`ifdef AXIS_UPSIZER_TKEEP_EN
        chk("basic_keep", m_axis_tkeep, 2'b11);
`endif
        cyc();
        chk("basic_drop", m_axis_tvalid, 1'b0);

        // odd tail
        send(32'hAAAA_0001, 1'b0);
        send(32'hBBBB_0002, 1'b0);
        chk("tail_w0_data", m_axis_tdata, 64'hBBBB0002_AAAA0001);
        chk("tail_w0_last", m_axis_tlast, 1'b0);
        send(32'hCCCC_0003, 1'b1);
        chk("tail_w1_valid", m_axis_tvalid, 1'b1);
        chk("tail_w1_data", m_axis_tdata, 64'h00000000_CCCC0003);
        chk("tail_w1_last", m_axis_tlast, 1'b1);
`ifdef AXIS_UPSIZER_TKEEP_EN
        chk("tail_w1_keep", m_axis_tkeep, 2'b01);
`endif
        cyc();
        chk("tail_drop", m_axis_tvalid, 1'b0);

        // back-pressure
        m_axis_tready = 1'b0;
        send(32'hD000_000D, 1'b0);
        send(32'hE000_000E, 1'b0);
        chk("bp_held_valid", m_axis_tvalid, 1'b1);
        chk("bp_held_data", m_axis_tdata, 64'hE000000E_D000000D);
        send(32'hF000_000F, 1'b0);
        chk("bp_fill_data", m_axis_tdata, 64'hE000000E_D000000D);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h6000_0006;
        s_axis_tlast  = 1'b0;
        #1;
        chk("bp_stall", s_axis_tready, 1'b0);
        cyc();
        chk("bp_stall2", s_axis_tready, 1'b0);
        chk("bp_stable", m_axis_tdata, 64'hE000000E_D000000D);
        m_axis_tready = 1'b1;
        #1;
        chk("bp_release", s_axis_tready, 1'b1);
        cyc();
        s_axis_tvalid = 1'b0;
        chk("bp_w2_valid", m_axis_tvalid, 1'b1);
        chk("bp_w2_data", m_axis_tdata, 64'h60000006_F000000F);
        cyc();
        chk("bp_drop", m_axis_tvalid, 1'b0);

        // full rate
        w0 = words_out;
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h100 + i;
            s_axis_tlast  = 1'b0;
            #1;
            chk("fr_ready", s_axis_tready, 1'b1);
            cyc();
            chk("fr_valid", m_axis_tvalid, (i % 2 == 1));
        end
        s_axis_tvalid = 1'b0;
        cyc();
        chk("fr_words", words_out - w0, 4);

        // reset mid-packet with a pending word and a buffered beat
        m_axis_tready = 1'b0;
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b0);
        areset = 1'b1;
        #1;
        chk("rmid_valid", m_axis_tvalid, 1'b0);
        chk("rmid_data", m_axis_tdata, 64'h0);
        chk("rmid_last", m_axis_tlast, 1'b0);
        cyc();
        areset        = 1'b0;
        m_axis_tready = 1'b1;
        send(32'h4444_4444, 1'b0);
        chk("rmid_novalid", m_axis_tvalid, 1'b0);
        send(32'h5555_5555, 1'b0);
        chk("rmid_word_valid", m_axis_tvalid, 1'b1);
        chk("rmid_word_data", m_axis_tdata, 64'h55555555_44444444);
        cyc();

        // randomized stream with random back-pressure
        idx   = 0;
        cyc_n = 0;
        cur_d = $urandom;
        cur_l = ($urandom % 4 == 0);
        while (idx < 300 && cyc_n < 5000) begin
            m_axis_tready = ($urandom % 3 != 0);
            if (!s_axis_tvalid) s_axis_tvalid = ($urandom % 4 != 0);
            s_axis_tdata = cur_d;
            s_axis_tlast = (idx == 299) ? 1'b1 : cur_l;
            #1;
            acc = s_axis_tvalid && s_axis_tready;
            cyc();
            cyc_n++;
            if (acc) begin
                idx++;
                s_axis_tvalid = 1'b0;
                cur_d = $urandom;
                cur_l = ($urandom % 4 == 0);
            end
        end
        chk("rand_done", idx, 300);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_partial", part.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
